// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer with in-order commit, writeback bypass on lookup
// and misprediction flush against the per-entry predicted-taken bit.
module rob_param #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int NUM_WB = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 dis_valid,
  input  logic [1:0]           dis_kind,
  input  logic [4:0]           dis_rd,
  input  logic [31:0]          dis_pc,
  input  logic                 dis_pred_taken,
  output logic [IDX_W-1:0]     dis_idx,
  output logic                 full,
  output logic [IDX_W:0]       count,
  input  logic [IDX_W-1:0]     q1_idx,
  input  logic [IDX_W-1:0]     q2_idx,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [31:0]          q1_val,
  output logic [31:0]          q2_val,
  input  logic [NUM_WB-1:0]    wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_idx,
  input  logic [NUM_WB*32-1:0] wb_val,
  input  logic [NUM_WB-1:0]    wb_taken,
  input  logic [NUM_WB*32-1:0] wb_target,
  output logic                 head_valid,
  output logic [IDX_W-1:0]     head_idx,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [IDX_W-1:0]     rf_idx,
  output logic [31:0]          rf_val,
  output logic                 st_commit,
  output logic [IDX_W-1:0]     st_idx,
  output logic                 flush,
  output logic [31:0]          flush_pc
);
  localparam logic [1:0] K_REG = 2'd0, K_ST = 2'd1, K_BR = 2'd2, K_JMP = 2'd3;
  logic [DEPTH-1:0] e_valid, e_ready, e_pred, e_taken;
  logic [1:0]  e_kind   [DEPTH];
  logic [4:0]  e_rd     [DEPTH];
  logic [31:0] e_pc     [DEPTH];
  logic [31:0] e_val    [DEPTH];
  logic [31:0] e_target [DEPTH];
  logic [IDX_W-1:0] head, tail;
  logic dis_ok, commit, h_rf, h_st, h_mis;
  logic [31:0] h_fpc;
  logic [32:0] q1_byp, q2_byp;

  // {hit, value} of the highest-numbered writeback port targeting idx this cycle
  function automatic logic [32:0] bypass(input logic [IDX_W-1:0] idx);
    bypass = '0;
    for (int p = 0; p < NUM_WB; p++)
      if (wb_valid[p] && wb_idx[p*IDX_W +: IDX_W] == idx) bypass = {1'b1, wb_val[p*32 +: 32]};
  endfunction

  assign dis_idx    = tail;
  assign head_idx   = head;
  assign head_valid = count != '0;
  assign full       = count == (IDX_W+1)'(DEPTH);
  assign dis_ok     = dis_valid && rdy && !flush && !full;
  assign commit     = rdy && !flush && head_valid && e_ready[head];
  assign h_rf       = e_kind[head] == K_REG || e_kind[head] == K_JMP;
  assign h_st       = e_kind[head] == K_ST;
  assign h_mis      = e_kind[head] == K_BR ? e_taken[head] != e_pred[head]
                                           : e_kind[head] == K_JMP && !e_pred[head];
  assign h_fpc      = (e_kind[head] == K_JMP || e_taken[head]) ? e_target[head] : e_pc[head] + 32'd4;
  assign q1_byp     = bypass(q1_idx);
  assign q2_byp     = bypass(q2_idx);
  assign q1_ready   = e_valid[q1_idx] && (e_ready[q1_idx] || q1_byp[32]);
  assign q2_ready   = e_valid[q2_idx] && (e_ready[q2_idx] || q2_byp[32]);
  assign q1_val     = q1_byp[32] ? q1_byp[31:0] : e_val[q1_idx];
  assign q2_val     = q2_byp[32] ? q2_byp[31:0] : e_val[q2_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      e_valid   <= '0;
      e_ready   <= '0;
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_idx    <= '0;
      rf_val    <= '0;
      st_commit <= 1'b0;
      st_idx    <= '0;
      flush     <= 1'b0;
      flush_pc  <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      e_valid   <= '0;
      e_ready   <= '0;
      rf_we     <= 1'b0;
      st_commit <= 1'b0;
      flush     <= 1'b0;
    end else begin
      rf_we     <= 1'b0;
      st_commit <= 1'b0;
      flush     <= 1'b0;
      if (rdy) begin
        if (dis_ok) begin
          e_valid[tail]  <= 1'b1;
          e_ready[tail]  <= dis_kind == K_ST;
          e_kind[tail]   <= dis_kind;
          e_rd[tail]     <= dis_rd;
          e_pc[tail]     <= dis_pc;
          e_pred[tail]   <= dis_pred_taken;
          tail           <= tail + 1'b1;
        end
        // later ports overwrite earlier ones, so the highest-numbered port wins
        for (int p = 0; p < NUM_WB; p++)
          if (wb_valid[p] && e_valid[wb_idx[p*IDX_W +: IDX_W]]) begin
            e_ready[wb_idx[p*IDX_W +: IDX_W]]  <= 1'b1;
            e_val[wb_idx[p*IDX_W +: IDX_W]]    <= wb_val[p*32 +: 32];
            e_taken[wb_idx[p*IDX_W +: IDX_W]]  <= wb_taken[p];
            e_target[wb_idx[p*IDX_W +: IDX_W]] <= wb_target[p*32 +: 32];
          end
        if (commit) begin
          head          <= head + 1'b1;
          e_valid[head] <= 1'b0;
          e_ready[head] <= 1'b0;
          rf_we         <= h_rf;
          st_commit     <= h_st;
          flush         <= h_mis;
          if (h_rf) begin
            rf_rd  <= e_rd[head];
            rf_idx <= head;
            rf_val <= e_val[head];
          end
          if (h_st) st_idx <= head;
          if (h_mis) flush_pc <= h_fpc;
        end
        count <= count + (IDX_W+1)'(dis_ok) - (IDX_W+1)'(commit);
      end
    end
  end
endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: scoreboard bench for rob_param at DEPTH=4; expected commits are queued at
// dispatch and checked by a monitor as pulses appear, scenario tasks check timing inline.
module tb_rob_param;
  localparam int DEPTH = 4, IDX_W = 2, NUM_WB = 2;
  localparam logic [1:0] K_REG = 2'd0, K_ST = 2'd1, K_BR = 2'd2;
  logic clk = 1'b0, rst, rdy, dis_valid, dis_pred_taken, full;
  logic [1:0] dis_kind;
  logic [4:0] dis_rd, rf_rd;
  logic [31:0] dis_pc, q1_val, q2_val, rf_val, flush_pc;
  logic [IDX_W-1:0] dis_idx, q1_idx, q2_idx, head_idx, rf_idx, st_idx;
  logic [IDX_W:0] count;
  logic q1_ready, q2_ready, head_valid, rf_we, st_commit, flush;
  logic [NUM_WB-1:0] wb_valid, wb_taken;
  logic [NUM_WB*IDX_W-1:0] wb_idx;
  logic [NUM_WB*32-1:0] wb_val, wb_target;
  typedef struct {logic [1:0] typ; logic [IDX_W-1:0] idx; logic [31:0] val;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  bit mon_en = 0;

  rob_param #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .dis_valid(dis_valid), .dis_kind(dis_kind), .dis_rd(dis_rd),
    .dis_pc(dis_pc), .dis_pred_taken(dis_pred_taken), .dis_idx(dis_idx), .full(full), .count(count),
    .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_val(q1_val),
    .q2_val(q2_val), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val), .wb_taken(wb_taken),
    .wb_target(wb_target), .head_valid(head_valid), .head_idx(head_idx), .rf_we(rf_we), .rf_rd(rf_rd),
    .rf_idx(rf_idx), .rf_val(rf_val), .st_commit(st_commit), .st_idx(st_idx), .flush(flush),
    .flush_pc(flush_pc));

  always #5 clk = ~clk;

  // typ 0 = register write, 1 = store commit, 2 = flush
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (rf_we || st_commit || flush)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected rf_we=%0b st_commit=%0b flush=%0b required no pulse", rf_we, st_commit, flush);
      end else begin
        e = sb.pop_front();
        if (e.typ == 2'd0 && !(rf_we === 1'b1 && rf_idx === e.idx && rf_val === e.val)) begin
          errors++;
          $display("FAIL sb_rf got we=%0b idx=%0d val=%0d required idx=%0d val=%0d", rf_we, rf_idx, rf_val, e.idx, e.val);
        end
        if (e.typ == 2'd1 && !(st_commit === 1'b1 && rf_we === 1'b0 && st_idx === e.idx)) begin
          errors++;
          $display("FAIL sb_st got st=%0b idx=%0d required idx=%0d", st_commit, st_idx, e.idx);
        end
        if (e.typ == 2'd2 && !(flush === 1'b1 && flush_pc === e.val)) begin
          errors++;
          $display("FAIL sb_flush got flush=%0b pc=%h required pc=%h", flush, flush_pc, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; dis_valid = 1'b0; dis_kind = K_REG; dis_rd = '0; dis_pc = '0; dis_pred_taken = 1'b0;
    wb_valid = '0; wb_idx = '0; wb_val = '0; wb_taken = '0; wb_target = '0; q1_idx = '0; q2_idx = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic dispatch(input logic [1:0] k, input logic [31:0] pc, input logic pt);
    dis_valid = 1'b1; dis_kind = k; dis_rd = pc[6:2]; dis_pc = pc; dis_pred_taken = pt;
    tick();
    dis_valid = 1'b0;
  endtask

  task automatic wb(input int p, input logic [IDX_W-1:0] i, input logic [31:0] v, input logic t,
                    input logic [31:0] tg);
    wb_valid[p] = 1'b1; wb_idx[p*IDX_W +: IDX_W] = i; wb_val[p*32 +: 32] = v;
    wb_taken[p] = t; wb_target[p*32 +: 32] = tg;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    mon_en = 0;
    for (int c = 0; c < 30; c++) begin
      dis_valid = 1'($urandom); dis_kind = 2'($urandom); dis_pc = $urandom; dis_pred_taken = 1'($urandom);
      wb_valid = 2'($urandom); wb_idx = 4'($urandom); wb_val = {$urandom, $urandom};
      wb_taken = 2'($urandom); wb_target = {$urandom, $urandom};
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({count, dis_idx, full, head_valid, head_idx, rf_we, st_commit, flush, flush_pc, rf_val, rf_idx, st_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got count=%0d dis_idx=%0d full=%0b hv=%0b we=%0b st=%0b fl=%0b fpc=%h rf_val=%h required all 0",
               count, dis_idx, full, head_valid, rf_we, st_commit, flush, flush_pc, rf_val);
    end
    checks++;
    if (q1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_q1_ready got %0b required 0", q1_ready);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({count, rf_we, st_commit, flush} !== '0) begin
      errors++;
      $display("FAIL post_reset got count=%0d we=%0b st=%0b fl=%0b required 0", count, rf_we, st_commit, flush);
    end
    sb.delete();
    mon_en = 1;
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dis_idx !== IDX_W'(i % DEPTH)) begin
        errors++;
        $display("FAIL fill_dis_idx got %0d required %0d", dis_idx, i % DEPTH);
      end
      if (i < DEPTH) sb.push_back('{2'd0, IDX_W'(i), 32'(10 + i)});
      dispatch(K_REG, 32'h1000 + 32'(4 * i), 1'b0);
    end
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || head_idx !== dis_idx) begin
      errors++;
      $display("FAIL fill_full got full=%0b count=%0d head=%0d tail=%0d required 1 4 equal", full, count, head_idx, dis_idx);
    end
    for (int i = 0; i < DEPTH; i++) begin
      wb(0, IDX_W'(i), 32'(10 + i), 1'b0, '0);
      tick();
      wb_valid = '0;
    end
    drain();
    checks++;
    if (count !== 3'd0 || head_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_empty got count=%0d hv=%0b required 0 0", count, head_valid);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dis_idx !== IDX_W'(i)) begin
        errors++;
        $display("FAIL wrap_dis_idx got %0d required %0d", dis_idx, i);
      end
      sb.push_back('{2'd0, IDX_W'(i), 32'(20 + i)});
      dispatch(K_REG, 32'h2000 + 32'(4 * i), 1'b0);
    end
    wb(0, 2'd0, 32'd20, 1'b0, '0);
    wb(1, 2'd1, 32'd21, 1'b0, '0);
    tick();
    wb_valid = '0;
    drain();
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{2'd0, IDX_W'(i), 32'(30 + i)});
      dispatch(K_REG, 32'h3000 + 32'(4 * i), 1'b0);
    end
    wb(0, 2'd2, 32'd32, 1'b0, '0);
    tick();
    wb_valid = '0;
    wb(0, 2'd0, 32'd30, 1'b0, '0);
    tick();
    wb_valid = '0;
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL ooo_early got rf_we=%0b required 0", rf_we);
    end
    wb(0, 2'd1, 32'd31, 1'b0, '0);
    tick();
    wb_valid = '0;
    checks++;
    if (rf_we !== 1'b1 || rf_idx !== 2'd0) begin
      errors++;
      $display("FAIL ooo_latency got rf_we=%0b rf_idx=%0d required 1 0", rf_we, rf_idx);
    end
    drain();
  endtask

  task automatic test_mispredict();
    logic pred [3] = '{1'b0, 1'b1, 1'b1};
    logic tkn  [3] = '{1'b1, 1'b0, 1'b1};
    logic fl   [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] fpc [3] = '{32'h200, 32'h104, 32'h200};
    logic [IDX_W-1:0] b;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      b = dis_idx;
      checks++;
      if (b !== '0) begin
        errors++;
        $display("FAIL mis_start_idx case %0d got %0d required 0", c, b);
      end
      if (fl[c]) sb.push_back('{2'd2, '0, fpc[c]});
      dispatch(K_BR, 32'h100, pred[c]);
      dispatch(K_REG, 32'h104, 1'b0);
      dispatch(K_REG, 32'h108, 1'b0);
      wb(0, b, 32'd0, tkn[c], 32'h200);
      tick();
      wb_valid = '0;
      checks++;
      if (flush !== 1'b0) begin
        errors++;
        $display("FAIL mis_early case %0d got flush=%0b required 0", c, flush);
      end
      tick();
      checks++;
      if (flush !== fl[c] || (fl[c] && flush_pc !== fpc[c])) begin
        errors++;
        $display("FAIL mis_flush case %0d got flush=%0b pc=%h required %0b %h", c, flush, flush_pc, fl[c], fpc[c]);
      end
      if (fl[c]) begin
        dis_valid = 1'b1;
        tick();
        dis_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || dis_idx !== 2'd0 || flush !== 1'b0) begin
          errors++;
          $display("FAIL mis_clear case %0d got count=%0d dis_idx=%0d flush=%0b required 0 0 0", c, count, dis_idx, flush);
        end
      end else begin
        checks++;
        if (count !== 3'd2 || head_idx !== b + 1'b1) begin
          errors++;
          $display("FAIL mis_none got count=%0d head=%0d required 2 %0d", count, head_idx, b + 1'b1);
        end
      end
    end
  endtask

  task automatic test_wb_conflict();
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(K_REG, 32'h4000 + 32'(4 * i), 1'b0);
    sb.push_back('{2'd0, 2'd0, 32'd40});
    sb.push_back('{2'd0, 2'd1, 32'd41});
    sb.push_back('{2'd0, 2'd2, 32'd42});
    sb.push_back('{2'd0, 2'd3, 32'd7});
    wb(0, 2'd3, 32'd5, 1'b0, '0);
    wb(1, 2'd3, 32'd7, 1'b0, '0);
    q1_idx = 2'd3;
    q2_idx = 2'd2;
    #1;
    checks++;
    if (q1_ready !== 1'b1 || q1_val !== 32'd7) begin
      errors++;
      $display("FAIL bypass_q1 got ready=%0b val=%0d required 1 7", q1_ready, q1_val);
    end
    checks++;
    if (q2_ready !== 1'b0) begin
      errors++;
      $display("FAIL bypass_q2 got ready=%0b required 0", q2_ready);
    end
    tick();
    wb_valid = '0;
    #1;
    checks++;
    if (q1_ready !== 1'b1 || q1_val !== 32'd7) begin
      errors++;
      $display("FAIL stored_q1 got ready=%0b val=%0d required 1 7", q1_ready, q1_val);
    end
    wb(0, 2'd0, 32'd40, 1'b0, '0);
    wb(1, 2'd1, 32'd41, 1'b0, '0);
    tick();
    wb_valid = '0;
    wb(0, 2'd2, 32'd42, 1'b0, '0);
    tick();
    wb_valid = '0;
    drain();
  endtask

  task automatic test_rdy_stall();
    do_reset();
    sb.push_back('{2'd1, 2'd0, '0});
    dispatch(K_ST, 32'h5000, 1'b0);
    checks++;
    if (st_commit !== 1'b0) begin
      errors++;
      $display("FAIL store_early got st=%0b required 0", st_commit);
    end
    tick();
    checks++;
    if (st_commit !== 1'b1 || st_idx !== 2'd0) begin
      errors++;
      $display("FAIL store_latency got st=%0b idx=%0d required 1 0", st_commit, st_idx);
    end
    sb.push_back('{2'd1, 2'd1, '0});
    dispatch(K_ST, 32'h5004, 1'b0);
    rdy = 1'b0;
    dis_valid = 1'b1;
    dis_kind = K_REG;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({rf_we, st_commit, flush} !== 3'b0 || count !== 3'd1 || dis_idx !== 2'd2) begin
        errors++;
        $display("FAIL stall cycle %0d got pulses=%b count=%0d dis_idx=%0d required 000 1 2", c, {rf_we, st_commit, flush}, count, dis_idx);
      end
    end
    rdy = 1'b1;
    dis_valid = 1'b0;
    tick();
    checks++;
    if (st_commit !== 1'b1 || st_idx !== 2'd1 || count !== 3'd0) begin
      errors++;
      $display("FAIL stall_release got st=%0b idx=%0d count=%0d required 1 1 0", st_commit, st_idx, count);
    end
    drain();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    test_reset();
    test_fill_wrap();
    test_out_of_order();
    test_mispredict();
    test_wb_conflict();
    test_rdy_stall();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
